// File: rtl/robin_pkg.sv
// Shared definitions for the robin SoC uart transmit path: byte width and the
// transmit-queue sequencer state encoding.
package robin_pkg;

   localparam int BYTE_W = 8;

   typedef enum logic [2:0] {
      ST_IDLE      = 3'd0,
      ST_LOAD      = 3'd1,
      ST_START     = 3'd2,
      ST_WAIT_BUSY = 3'd3,
      ST_WAIT_DONE = 3'd4
   } tx_state_t;

endpackage

// File: rtl/tx_fifo.sv
// Byte FIFO with wrap-bit pointers and a registered (synchronous) read port,
// shaped so the storage maps onto a single block RAM.
module tx_fifo
   import robin_pkg::*;
#(
   parameter int ADDR_W = 4
) (
   input  logic              CLK,
   input  logic              rst,
   input  logic              write,
   input  logic [BYTE_W-1:0] data_in,
   input  logic              read,
   output logic [BYTE_W-1:0] data_out,
   output logic              full,
   output logic              empty,
   output logic [ADDR_W:0]   level
);

   localparam int DEPTH = 2 ** ADDR_W;

   logic [BYTE_W-1:0] mem_q [DEPTH];
   logic [BYTE_W-1:0] data_out_q;
   logic [ADDR_W:0]   wr_ptr_q, wr_ptr_d;
   logic [ADDR_W:0]   rd_ptr_q, rd_ptr_d;
   logic              do_write, do_read;

   // The extra pointer bit makes level span 0..DEPTH, so its MSB alone means full.
   assign level    = wr_ptr_q - rd_ptr_q;
   assign full     = level[ADDR_W];
   assign empty    = (level == '0);
   assign do_write = write & ~full;
   assign do_read  = read & ~empty;
   assign data_out = data_out_q;

   always_comb begin
      wr_ptr_d = wr_ptr_q;
      rd_ptr_d = rd_ptr_q;
      if (do_write) wr_ptr_d = wr_ptr_q + 1'b1;
      if (do_read)  rd_ptr_d = rd_ptr_q + 1'b1;
   end

   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         wr_ptr_q   <= '0;
         rd_ptr_q   <= '0;
         data_out_q <= '0;
      end else begin
         wr_ptr_q <= wr_ptr_d;
         rd_ptr_q <= rd_ptr_d;
         if (do_read) data_out_q <= mem_q[rd_ptr_q[ADDR_W-1:0]];
      end
   end

   always_ff @(posedge CLK) begin
      if (do_write) mem_q[wr_ptr_q[ADDR_W-1:0]] <= data_in;
   end

endmodule

// File: rtl/uart_tx_queue.sv
// Transmit byte queue: buffers producer writes and hands them one at a time to
// the uart, waiting for each frame to finish before popping the next byte.
module uart_tx_queue
   import robin_pkg::*;
#(
   parameter int FIFO_ADDR_WIDTH = 4,
   parameter int BUSY_TIMEOUT    = 4
) (
   input  logic                     CLK,
   input  logic                     rst,
   input  logic                     wr_en,
   input  logic [BYTE_W-1:0]        wr_data,
   output logic                     full,
   output logic                     empty,
   output logic [FIFO_ADDR_WIDTH:0] level,
   output logic                     overflow,
   output logic                     idle,
   output logic                     u_transmit,
   output logic [BYTE_W-1:0]        u_tx_byte,
   input  logic                     u_is_transmitting,
   output tx_state_t                dbg_state
);

   localparam int TMO_W = $clog2(BUSY_TIMEOUT + 1);

   tx_state_t         state_q;
   logic [TMO_W-1:0]  tmo_cnt_q;
   logic              overflow_q;
   logic              u_transmit_q;
   logic [BYTE_W-1:0] u_tx_byte_q;
   logic [BYTE_W-1:0] fifo_dout;
   logic              pop;

   assign pop = (state_q == ST_IDLE) & ~empty & ~u_is_transmitting;

   tx_fifo #(.ADDR_W(FIFO_ADDR_WIDTH)) u_fifo (
      .CLK      (CLK),
      .rst      (rst),
      .write    (wr_en),
      .data_in  (wr_data),
      .read     (pop),
      .data_out (fifo_dout),
      .full     (full),
      .empty    (empty),
      .level    (level)
   );

   always_ff @(posedge CLK or posedge rst) begin
      if (rst)                overflow_q <= 1'b0;
      else if (wr_en & full)  overflow_q <= 1'b1;
   end

   // The pulse is launched on leaving LOAD so it is high exactly while in START.
   always_ff @(posedge CLK or posedge rst) begin
      if (rst) begin
         state_q      <= ST_IDLE;
         tmo_cnt_q    <= '0;
         u_transmit_q <= 1'b0;
         u_tx_byte_q  <= '0;
      end else begin
         u_transmit_q <= 1'b0;
         case (state_q)
            ST_IDLE: begin
               if (pop) state_q <= ST_LOAD;
            end
            ST_LOAD: begin
               u_tx_byte_q  <= fifo_dout;
               u_transmit_q <= 1'b1;
               state_q      <= ST_START;
            end
            ST_START: begin
               tmo_cnt_q <= '0;
               state_q   <= ST_WAIT_BUSY;
            end
            ST_WAIT_BUSY: begin
               if (u_is_transmitting)                          state_q <= ST_WAIT_DONE;
               else if (tmo_cnt_q == TMO_W'(BUSY_TIMEOUT - 1)) state_q <= ST_IDLE;
               else                                            tmo_cnt_q <= tmo_cnt_q + 1'b1;
            end
            ST_WAIT_DONE: begin
               if (!u_is_transmitting) state_q <= ST_IDLE;
            end
            default: state_q <= ST_IDLE;
         endcase
      end
   end

   assign overflow   = overflow_q;
   assign idle       = empty & (state_q == ST_IDLE);
   assign u_transmit = u_transmit_q;
   assign u_tx_byte  = u_tx_byte_q;
   assign dbg_state  = state_q;

endmodule

// File: tb/tb_uart_tx_queue.sv
// Bench for uart_tx_queue: a behavioural uart model feeds a byte scoreboard,
// with table-driven fill vectors, directed corner sequences and random writes.
module tb_uart_tx_queue;
   import robin_pkg::*;

   localparam int AW    = 4;
   localparam int DEPTH = 16;
   localparam int TMO   = 4;
   localparam int M_NORMAL = 0, M_HOLD = 1, M_DEAD = 2;

   // ---------------- clock / reset / DUT ----------------
   logic        clk = 1'b0;
   logic        rst;
   logic        wr_en = 1'b0;
   logic [7:0]  wr_data = 8'h00;
   logic        full, empty, overflow, idle, u_transmit;
   logic [AW:0] level;
   logic [7:0]  u_tx_byte;
   logic        u_is_transmitting;
   tx_state_t   dbg_state;

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   uart_tx_queue #(.FIFO_ADDR_WIDTH(AW), .BUSY_TIMEOUT(TMO)) dut (
      .CLK               (clk),
      .rst               (rst),
      .wr_en             (wr_en),
      .wr_data           (wr_data),
      .full              (full),
      .empty             (empty),
      .level             (level),
      .overflow          (overflow),
      .idle              (idle),
      .u_transmit        (u_transmit),
      .u_tx_byte         (u_tx_byte),
      .u_is_transmitting (u_is_transmitting),
      .dbg_state         (dbg_state)
   );

   // ---------------- scoreboard state ----------------
   int         errors = 0;
   int         checks = 0;
   logic [7:0] exp_q[$];
   int         pulse_cyc_q[$];

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   // ---------------- uart model ----------------
   int mode = M_NORMAL;
   int busy_min = 1, busy_max = 4;
   int busy_left = 0;
   bit start_next = 0;
   bit prev_tx = 0;

   initial begin
      u_is_transmitting = 1'b0;
      forever begin
         @(posedge clk); #2;
         if (u_transmit === 1'b1) begin
            check("tx_not_while_busy", u_is_transmitting, 0);
            check("tx_single_cycle", prev_tx, 0);
            pulse_cyc_q.push_back(cyc);
            if (exp_q.size() == 0) begin
               checks++;
               errors++;
               $display("FAIL unexpected_byte: got %02h with nothing expected (cycle %0d)", u_tx_byte, cyc);
            end else begin
               check("tx_byte_order", u_tx_byte, exp_q.pop_front());
            end
         end
         prev_tx = (u_transmit === 1'b1);
         case (mode)
            M_HOLD: u_is_transmitting = 1'b1;
            M_DEAD: begin
               busy_left = 0;
               start_next = 0;
               u_is_transmitting = 1'b0;
            end
            default: begin
               if (start_next) begin
                  busy_left  = $urandom_range(busy_max, busy_min);
                  start_next = 0;
               end else if (busy_left > 0) begin
                  busy_left--;
               end
               u_is_transmitting = (busy_left > 0);
               if (u_transmit === 1'b1) start_next = 1;
            end
         endcase
      end
   end

   // ---------------- driver tasks ----------------
   task automatic tick();
      @(posedge clk); #1;
   endtask

   task automatic do_reset();
      rst = 1'b1;
      wr_en = 1'b0;
      wr_data = 8'h00;
      repeat (2) tick();
      rst = 1'b0;
      exp_q.delete();
      pulse_cyc_q.delete();
      tick();
   endtask

   task automatic write_byte(input logic [7:0] b);
      wr_en = 1'b1;
      wr_data = b;
      tick();
      wr_en = 1'b0;
   endtask

   task automatic wait_idle(input string name, input int max_cyc);
      int n = 0;
      while (!(idle && !u_is_transmitting && !start_next && busy_left == 0) && n < max_cyc) begin
         tick();
         n++;
      end
      check({name, "_reached_idle"}, 32'(n < max_cyc), 1);
   endtask

   // ---------------- fill vectors ----------------
   typedef struct {
      logic       wr;
      logic [7:0] d;
      bit         acc;
      logic       exp_full;
      logic       exp_empty;
      logic [AW:0] exp_level;
      logic       exp_ovf;
   } vec_t;

   vec_t tbl[18];

   initial begin
      #200000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int t0, cnt, n;
      logic [7:0] b;

      // ---- 1: reset values and single-byte latency ----
      mode = M_NORMAL; busy_min = 2; busy_max = 3;
      do_reset();
      check("rst_full", full, 0);
      check("rst_empty", empty, 1);
      check("rst_level", level, 0);
      check("rst_overflow", overflow, 0);
      check("rst_idle", idle, 1);
      check("rst_u_transmit", u_transmit, 0);
      check("rst_u_tx_byte", u_tx_byte, 8'h00);
      t0 = cyc;
      exp_q.push_back(8'h41);
      write_byte(8'h41);
      wait_idle("t1", 100);
      check("t1_pulse_count", pulse_cyc_q.size(), 1);
      if (pulse_cyc_q.size() > 0) check("t1_latency", pulse_cyc_q[0] - t0, 3);
      check("t1_u_tx_byte", u_tx_byte, 8'h41);
      check("t1_idle", idle, 1);
      check("t1_drained", exp_q.size(), 0);

      // ---- 2: burst of DEPTH bytes ----
      busy_min = 1; busy_max = 3;
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         exp_q.push_back(8'(i));
         write_byte(8'(i));
      end
      check("t2_overflow", overflow, 0);
      check("t2_not_full", full, 0);
      wait_idle("t2", 400);
      check("t2_pulses", pulse_cyc_q.size(), DEPTH);
      check("t2_drained", exp_q.size(), 0);

      // ---- 3: table-driven fill with uart held busy ----
      cnt = 0;
      for (int i = 0; i < 18; i++) begin
         tbl[i].wr = (i < 17);
         tbl[i].d = 8'hA0 + 8'(i);
         tbl[i].acc = tbl[i].wr && (cnt < DEPTH);
         if (tbl[i].acc) cnt++;
         tbl[i].exp_level = (AW + 1)'(cnt);
         tbl[i].exp_full = (cnt == DEPTH);
         tbl[i].exp_empty = (cnt == 0);
         tbl[i].exp_ovf = (i >= 16);
      end
      mode = M_HOLD;
      do_reset();
      for (int i = 0; i < 18; i++) begin
         if (tbl[i].acc) exp_q.push_back(tbl[i].d);
         wr_en = tbl[i].wr;
         wr_data = tbl[i].d;
         tick();
         wr_en = 1'b0;
         check($sformatf("t3_full[%0d]", i), full, tbl[i].exp_full);
         check($sformatf("t3_empty[%0d]", i), empty, tbl[i].exp_empty);
         check($sformatf("t3_level[%0d]", i), level, tbl[i].exp_level);
         check($sformatf("t3_ovf[%0d]", i), overflow, tbl[i].exp_ovf);
      end
      mode = M_NORMAL; busy_min = 1; busy_max = 2;
      wait_idle("t3", 400);
      check("t3_pulses", pulse_cyc_q.size(), DEPTH);
      check("t3_drained", exp_q.size(), 0);
      check("t3_ovf_sticky", overflow, 1);

      // ---- 4: write in the pop cycle while full ----
      mode = M_HOLD;
      do_reset();
      for (int i = 0; i < DEPTH; i++) begin
         exp_q.push_back(8'h10 + 8'(i));
         write_byte(8'h10 + 8'(i));
      end
      check("t4_full", full, 1);
      check("t4_ovf_before", overflow, 0);
      mode = M_NORMAL;
      wr_en = 1'b1;
      wr_data = 8'hEE;
      tick();
      check("t4_ovf_pop_cycle", overflow, 1);
      check("t4_level_after_pop", level, DEPTH - 1);
      wr_data = 8'h77;
      exp_q.push_back(8'h77);
      tick();
      wr_en = 1'b0;
      check("t4_level_refill", level, DEPTH);
      check("t4_full_refill", full, 1);
      wait_idle("t4", 400);
      check("t4_pulses", pulse_cyc_q.size(), DEPTH + 1);
      check("t4_drained", exp_q.size(), 0);

      // ---- 5: uart never acknowledges ----
      mode = M_DEAD;
      do_reset();
      exp_q.push_back(8'hC1);
      write_byte(8'hC1);
      exp_q.push_back(8'hC2);
      write_byte(8'hC2);
      wait_idle("t5", 200);
      check("t5_pulses", pulse_cyc_q.size(), 2);
      if (pulse_cyc_q.size() >= 2) check("t5_gap", pulse_cyc_q[1] - pulse_cyc_q[0], TMO + 3);
      check("t5_drained", exp_q.size(), 0);

      // ---- 6: reset during a frame ----
      mode = M_NORMAL; busy_min = 30; busy_max = 30;
      do_reset();
      for (int i = 0; i < 6; i++) begin
         exp_q.push_back(8'h60 + 8'(i));
         write_byte(8'h60 + 8'(i));
      end
      n = 0;
      while (pulse_cyc_q.size() == 0 && n < 50) begin
         tick();
         n++;
      end
      check("t6_first_pulse", 32'(n < 50), 1);
      repeat (4) tick();
      check("t6_state", dbg_state, ST_WAIT_DONE);
      check("t6_level_queued", level, 5);
      check("t6_sb_queued", exp_q.size(), 5);
      rst = 1'b1;
      #1;
      check("t6_rst_empty", empty, 1);
      check("t6_rst_level", level, 0);
      check("t6_rst_u_transmit", u_transmit, 0);
      check("t6_rst_idle", idle, 1);
      exp_q.delete();
      pulse_cyc_q.delete();
      tick();
      tick();
      rst = 1'b0;
      tick();
      check("t6_uart_still_busy", u_is_transmitting, 1);
      exp_q.push_back(8'h55);
      write_byte(8'h55);
      wait_idle("t6", 200);
      check("t6_pulses", pulse_cyc_q.size(), 1);
      check("t6_u_tx_byte", u_tx_byte, 8'h55);

      // ---- 7: random writes, gated so the queue never fills ----
      busy_min = 1; busy_max = 4;
      do_reset();
      cnt = 0;
      for (int i = 0; i < 300; i++) begin
         if ($urandom_range(2, 0) != 0 && exp_q.size() < DEPTH) begin
            b = 8'($urandom);
            exp_q.push_back(b);
            cnt++;
            write_byte(b);
         end else begin
            tick();
         end
         check("rnd_level_bound", 32'(int'(level) <= exp_q.size()), 1);
      end
      wait_idle("rnd", 400);
      check("rnd_pulses", pulse_cyc_q.size(), cnt);
      check("rnd_drained", exp_q.size(), 0);
      check("rnd_no_overflow", overflow, 0);

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end

endmodule
